// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF line synchronizer, mid-bit sampling, start-glitch rejection,
// framing-error pulse and a one-deep holding register with valid/ack and sticky overrun.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_error,
    output logic       overrun
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_ferr;
    logic            r_ovr;

    logic w_rxd_s;
    logic w_bit_end;
    logic w_load;

    assign w_rxd_s   = r_sync2;
    assign w_bit_end = (r_cnt == CntLast);
    assign w_load    = (r_state == StStop) && w_bit_end && w_rxd_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
            r_ferr  <= 1'b0;

            // A load wins over ack; an ack in the same cycle only suppresses overrun.
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (rx_ack) begin
                    r_ovr <= 1'b0;
                end else if (r_valid) begin
                    r_ovr <= 1'b1;
                end
            end else if (rx_ack) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (!w_rxd_s) begin
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    if (r_cnt == CntHalf) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_rxd_s ? StIdle : StData;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxd_s, r_shift[7:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == 3'd7) begin
                            r_state <= StStop;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_rxd_s) begin
                            r_state <= StIdle;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= StBreak;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StBreak: begin
                    // Hold here until the line recovers so a stuck-low line flags only once.
                    r_cnt <= '0;
                    if (w_rxd_s) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign rx_busy     = (r_state != StIdle);
    assign frame_error = r_ferr;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand sequences for the multi-cycle
// corner cases, and random frames checked against a frame-level handshake model.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       reset;
    logic       uart_rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_error;
    logic       overrun;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rxd   (uart_rxd),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Event counters sampled on the falling edge, away from the active edge.
    int   n_ferr = 0;
    int   n_vrise = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (frame_error) n_ferr++;
        if (rx_valid && !prev_valid) n_vrise++;
        prev_valid = rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Drives one 8N1 frame; ack_first pulses rx_ack during the first start-bit cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_first);
        uart_rxd = 1'b0;
        if (ack_first) begin
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
            repeat (CPB - 1) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ovr;
        int         exp_ferr;
        int         exp_vrise;
    } vec_t;

    vec_t vecs[6];

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;
    int         f0;
    int         v0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0, 1};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 0, 1};
        vecs[2] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 0, 1};
        vecs[3] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 0, 1};
        vecs[4] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 0, 0};
        vecs[5] = '{8'h81, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1, 0};

        reset    = 1'b1;
        uart_rxd = 1'b1;
        rx_ack   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", int'(rx_data), 0);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_busy", int'(rx_busy), 0);
        check("rst_ferr", int'(frame_error), 0);
        check("rst_ovr", int'(overrun), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Directed frame table, idle line between frames.
        for (int r = 0; r < 6; r++) begin
            f0 = n_ferr;
            v0 = n_vrise;
            send_frame(vecs[r].data, vecs[r].stop, 1'b0);
            if (!vecs[r].stop) repeat (40) @(negedge clk);
            uart_rxd = 1'b1;
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_data", r), int'(rx_data), int'(vecs[r].exp_data));
            check($sformatf("vec%0d_valid", r), int'(rx_valid), int'(vecs[r].exp_valid));
            check($sformatf("vec%0d_ovr", r), int'(overrun), int'(vecs[r].exp_ovr));
            check($sformatf("vec%0d_ferr", r), n_ferr - f0, vecs[r].exp_ferr);
            check($sformatf("vec%0d_vrise", r), n_vrise - v0, vecs[r].exp_vrise);
            check($sformatf("vec%0d_busy", r), int'(rx_busy), 0);
            if (vecs[r].ack) begin
                pulse_ack();
                check($sformatf("vec%0d_ack_valid", r), int'(rx_valid), 0);
                check($sformatf("vec%0d_ack_ovr", r), int'(overrun), 0);
            end
        end

        // Back-to-back frames, ack folded into the next start bit.
        v0 = n_vrise;
        send_frame(8'h3C, 1'b1, 1'b0);
        check("b2b_first", int'(rx_data), 8'h3C);
        send_frame(8'hC3, 1'b1, 1'b1);
        check("b2b_second", int'(rx_data), 8'hC3);
        check("b2b_valid", int'(rx_valid), 1);
        check("b2b_ovr", int'(overrun), 0);
        check("b2b_vrise", n_vrise - v0, 2);
        uart_rxd = 1'b1;
        repeat (10) @(negedge clk);
        pulse_ack();

        // Short low glitch must be rejected in START.
        f0 = n_ferr;
        v0 = n_vrise;
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy", int'(rx_busy), 1);
        repeat (20) @(negedge clk);
        check("glitch_idle", int'(rx_busy), 0);
        check("glitch_vrise", n_vrise - v0, 0);
        check("glitch_ferr", n_ferr - f0, 0);
        send_frame(8'h7E, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("post_glitch_data", int'(rx_data), 8'h7E);
        check("post_glitch_valid", int'(rx_valid), 1);
        pulse_ack();

        // Random frames against a frame-level handshake model.
        m_data  = 8'h7E;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            logic       bad;
            logic       ackf;
            int         gap;
            b    = 8'($urandom);
            bad  = ($urandom_range(0, 7) == 0);
            ackf = 1'($urandom_range(0, 1));
            gap  = bad ? int'($urandom_range(5, 20)) : int'($urandom_range(0, 20));
            if (ackf) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            f0 = n_ferr;
            send_frame(b, !bad, ackf);
            if (!bad) begin
                if (m_valid) m_ovr = 1'b1;
                m_data  = b;
                m_valid = 1'b1;
            end
            check($sformatf("rnd%0d_data", k), int'(rx_data), int'(m_data));
            check($sformatf("rnd%0d_valid", k), int'(rx_valid), int'(m_valid));
            check($sformatf("rnd%0d_ovr", k), int'(overrun), int'(m_ovr));
            check($sformatf("rnd%0d_ferr", k), n_ferr - f0, bad ? 1 : 0);
            uart_rxd = 1'b1;
            repeat (gap) @(negedge clk);
        end
        repeat (10) @(negedge clk);

        // Reset in the middle of bit 4 of 0xFF, with a byte already held.
        send_frame(8'h99, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (CPB * 4 + 8) @(negedge clk);
        check("mid_busy", int'(rx_busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_data", int'(rx_data), 0);
        check("mrst_valid", int'(rx_valid), 0);
        check("mrst_busy", int'(rx_busy), 0);
        check("mrst_ovr", int'(overrun), 0);
        check("mrst_ferr", int'(frame_error), 0);
        repeat (CPB * 5) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("after_rst_data", int'(rx_data), 8'h12);
        check("after_rst_valid", int'(rx_valid), 1);
        check("after_rst_ovr", int'(overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
